dmem_bytelane: RTL and testbench
================================

# dmem_bytelane

Parametrised data memory for the CompArc datapath. It supersedes the fixed word-only dmem. It adds configurable width and depth, byte/half/word stores with lane masking, and sign- or zero-extended loads. It also adds alignment and range fault detection, a registered read response with a valid strobe, and a post-reset zero-initialisation sweep. It sits between the execute stage and the writeback mux, and is addressed with byte addresses from the ALU.

## Interface
- DATA_WIDTH, 32: word width in bits; a multiple of 16, ≥16.
- DEPTH, 256: number of words.
- ADDR_WIDTH, 32: width of the byte address.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  request qualifier; write_enable/read_enable ignored when 0.
- write_enable  in  1  store request.
- read_enable  in  1  load request.
- memory_address  in  ADDR_WIDTH  byte address.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_load  in  1  1 = zero-extend, 0 = sign-extend (byte/half loads only).
- data_in  in  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
- data_out  out  DATA_WIDTH  registered, extended load result.
- read_valid  out  1  one-cycle pulse marking data_out updated.
- fault  out  1  one-cycle pulse: rejected request.
- busy  out  1  high during init sweep; requests ignored.

## Operation
- FSM states: INIT, IDLE, RESP.
  - INIT: a word counter writes 0 to one word per cycle, 0 to DEPTH-1. busy=1. Moves to IDLE after word DEPTH-1 is written.
  - IDLE: accepts requests.
  - RESP: one-cycle state after an accepted read or a faulted request. It drives read_valid and/or fault, and it also accepts a new request (back-to-back throughput, one request per cycle).
- A request is present when enable=1, busy=0, and write_enable or read_enable is 1.
- Fault conditions (any one faults the request):
  - size=11
  - half with addr[0]≠0
  - word with addr[log2(DATA_WIDTH/8)-1:0]≠0
  - memory_address ≥ DEPTH*DATA_WIDTH/8
  - write_enable and read_enable both 1
- A faulted request writes nothing, leaves data_out unchanged, pulses fault, and keeps read_valid=0.
- Store: data_in is replicated into the addressed lane(s); only the lanes selected by the byte mask are written.
- Load: the addressed lane(s) are extracted and extended to DATA_WIDTH. Word loads ignore unsigned_load.
- data_out holds its value between responses.

## Timing
- Reset (asynchronous, reset=0):
  - data_out=0, read_valid=0, fault=0, busy=1.
  - State goes to INIT and the counter to 0.
  - An in-flight read response is lost.
  - Memory contents are undefined until the INIT sweep completes.
- INIT lasts exactly DEPTH cycles after reset release. busy falls on the edge that leaves INIT.
- Store commits on the rising edge that samples the request. It is visible to a load sampled on the next edge.
- Load latency is 1 cycle. A request sampled at edge N gives data_out and read_valid=1 after edge N, for one cycle.
- fault uses the same 1-cycle latency.
- Requests during busy=1 are dropped silently: no fault, no pulse.

## Structure
- dmem_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD)
  - state_t enum (INIT, IDLE, RESP)
  - function byte_mask(size, offset)
  - function is_aligned(size, offset)
- Sub-module dmem_load_extend is purely combinational: word, offset, size, unsigned_load → extended data. It is instantiated once and unit-testable.
- Storage is an inferred array of DEPTH words with a per-byte write mask.

## Test plan
All scenarios use DATA_WIDTH=32, DEPTH=256.
- Release reset → busy=1 for 256 cycles, then 0. A word read at 0x3FC then returns data_out=0x00000000 and read_valid pulses once.
- Word store 0x12345678 at 0x0, then word load at 0x0 → data_out=0x12345678 one cycle after the load. Back-to-back loads at 0x0 and 0x4 give two consecutive read_valid pulses.
- Byte store 0xAB at 0x5 after zero init:
  - word load 0x4 → 0x0000AB00
  - signed byte load 0x5 → 0xFFFFFFAB
  - unsigned byte load 0x5 → 0x000000AB
  - signed half load 0x4 → 0xFFFFAB00
- Each of the following pulses fault=1 with read_valid=0, and a word load at 0x0 still returns the prior contents:
  - half store at 0x3
  - word load at 0x2
  - word store at 0x400
  - size=11
  - write_enable=read_enable=1
- Assert reset the cycle after a load request → read_valid stays 0, data_out=0, busy=1, and the full 256-cycle INIT reruns.
- Request during busy (word store 0xDEADBEEF at 0x8) → no fault. After init, a load at 0x8 returns 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared types and lane/alignment helpers for dmem_bytelane.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_pkg;

  // Upper bound on byte lanes per word (DATA_WIDTH up to 512 bits).
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [MAX_LANES-1:0] byte_mask(input size_t sz, input logic [5:0] offset);
    logic [MAX_LANES-1:0] m;
    m = '0;
    case (sz)
      SZ_BYTE: m = MAX_LANES'(1) << offset;
      SZ_HALF: m = MAX_LANES'(3) << offset;
      SZ_WORD: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic is_aligned(input size_t sz, input logic [5:0] offset);
    logic ok;
    ok = 1'b0;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~offset[0];
      SZ_WORD: ok = (offset == 6'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_extend.sv
`default_nettype none
// ============================================================================
// Module : dmem_load_extend
// Brief  : Combinational lane extraction and sign/zero extension for loads.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_load_extend
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]               i_word,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]     i_offset,
  input  logic [1:0]                          i_size,
  input  logic                                i_unsigned,
  output logic [DATA_WIDTH-1:0]               o_data
);

  logic [DATA_WIDTH-1:0] w_sh;
  size_t                 w_size;

  assign w_size = size_t'(i_size);
  // Aligned word loads have offset 0, so the shifted word doubles as the word result.
  assign w_sh   = i_word >> {i_offset, 3'b000};

  always_comb begin
    o_data = '0;
    case (w_size)
      SZ_BYTE: o_data = {{(DATA_WIDTH-8){~i_unsigned & w_sh[7]}}, w_sh[7:0]};
      SZ_HALF: o_data = {{(DATA_WIDTH-16){~i_unsigned & w_sh[15]}}, w_sh[15:0]};
      SZ_WORD: o_data = w_sh;
      default: o_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module : dmem_bytelane
// Brief  : Byte-lane data memory with faults, registered loads, zero-init sweep.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] memory_address,
  input  logic [1:0]            size,
  input  logic                  unsigned_load,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  fault,
  output logic                  busy
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int WAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * NB);
  localparam logic [WAW-1:0]      c_LAST_WORD = WAW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state;
  logic [WAW-1:0]        r_cnt;

  size_t                 w_size;
  logic [OFFW-1:0]       w_offset;
  logic [WAW-1:0]        w_word_idx;
  logic                  w_req;
  logic                  w_fault;
  logic                  w_store;
  logic                  w_load;
  logic [NB-1:0]         w_mask;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_ext;
  logic                  w_init;
  logic                  w_mem_we;
  logic [WAW-1:0]        w_mem_idx;
  logic [NB-1:0]         w_mem_mask;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_size     = size_t'(size);
  assign w_offset   = memory_address[OFFW-1:0];
  assign w_word_idx = memory_address[OFFW +: WAW];

  assign w_req   = enable & ~busy & (write_enable | read_enable);
  // SZ_BAD is reported as misaligned by is_aligned, covering the illegal-size fault.
  assign w_fault = (write_enable & read_enable)
                 | ~is_aligned(w_size, 6'(w_offset))
                 | ({1'b0, memory_address} >= c_MEM_BYTES);
  assign w_store = w_req & ~w_fault & write_enable;
  assign w_load  = w_req & ~w_fault & read_enable;

  assign w_mask  = NB'(byte_mask(w_size, 6'(w_offset)));

  always_comb begin
    w_wdata = data_in;
    case (w_size)
      SZ_BYTE: w_wdata = {NB{data_in[7:0]}};
      SZ_HALF: w_wdata = {(NB/2){data_in[15:0]}};
      default: w_wdata = data_in;
    endcase
  end

  assign w_init      = (r_state == INIT);
  assign w_mem_we    = w_init | w_store;
  assign w_mem_idx   = w_init ? r_cnt : w_word_idx;
  assign w_mem_mask  = w_init ? {NB{1'b1}} : w_mask;
  assign w_mem_wdata = w_init ? '0 : w_wdata;

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (w_mem_mask[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  assign w_rd_word = r_mem[w_word_idx];

  dmem_load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extend (
    .i_word     (w_rd_word),
    .i_offset   (w_offset),
    .i_size     (size),
    .i_unsigned (unsigned_load),
    .o_data     (w_ext)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= INIT;
      r_cnt      <= '0;
      data_out   <= '0;
      read_valid <= 1'b0;
      fault      <= 1'b0;
      busy       <= 1'b1;
    end else begin
      read_valid <= 1'b0;
      fault      <= 1'b0;
      case (r_state)
        INIT: begin
          if (r_cnt == c_LAST_WORD) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE, RESP: begin
          r_state <= IDLE;
          if (w_req && w_fault) begin
            fault   <= 1'b1;
            r_state <= RESP;
          end else if (w_load) begin
            data_out   <= w_ext;
            read_valid <= 1'b1;
            r_state    <= RESP;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_bytelane
// Brief  : Directed self-checking bench for dmem_bytelane (32-bit x 256).
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_bytelane;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          write_enable;
  logic          read_enable;
  logic [AW-1:0] memory_address;
  logic [1:0]    size;
  logic          unsigned_load;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          read_valid;
  logic          fault;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc;

  dmem_bytelane #(
    .DATA_WIDTH (DW),
    .DEPTH      (256),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .write_enable   (write_enable),
    .read_enable    (read_enable),
    .memory_address (memory_address),
    .size           (size),
    .unsigned_load  (unsigned_load),
    .data_in        (data_in),
    .data_out       (data_out),
    .read_valid     (read_valid),
    .fault          (fault),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    memory_address = '0; size = 2'b00; unsigned_load = 1'b0; data_in = '0;
  endtask

  task automatic set_req(input logic we, input logic re, input logic [31:0] addr,
                         input logic [1:0] sz, input logic uns, input logic [31:0] din);
    enable = 1'b1; write_enable = we; read_enable = re;
    memory_address = addr; size = sz; unsigned_load = uns; data_in = din;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic we, input logic re, input logic [31:0] addr,
                    input logic [1:0] sz, input logic uns, input logic [31:0] din);
    set_req(we, re, addr, sz, uns, din);
    step();
    idle_inputs();
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] exp);
    op(1'b0, 1'b1, addr, sz, uns, 32'h0);
    check({tag, " read_valid"}, {31'b0, read_valid}, 32'h1);
    check({tag, " data_out"}, data_out, exp);
    check({tag, " fault"}, {31'b0, fault}, 32'h0);
  endtask

  task automatic fault_chk(input string tag, input logic we, input logic re,
                           input logic [31:0] addr, input logic [1:0] sz,
                           input logic [31:0] din, input logic [31:0] prev);
    op(we, re, addr, sz, 1'b0, din);
    check({tag, " fault"}, {31'b0, fault}, 32'h1);
    check({tag, " read_valid"}, {31'b0, read_valid}, 32'h0);
    check({tag, " data_out held"}, data_out, prev);
    step();
    check({tag, " fault pulse end"}, {31'b0, fault}, 32'h0);
    load_chk({tag, " word0 intact"}, 32'h0, 2'b10, 1'b0, 32'h12345678);
  endtask

  task automatic wait_init(input string tag);
    n_cyc = 0;
    do begin
      step();
      n_cyc++;
    end while (busy && n_cyc < 400);
    check({tag, " init edges"}, 32'(n_cyc), 32'd256);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    check("reset busy", {31'b0, busy}, 32'h1);
    check("reset data_out", data_out, 32'h0);
    check("reset read_valid", {31'b0, read_valid}, 32'h0);
    check("reset fault", {31'b0, fault}, 32'h0);
    reset = 1'b1;
    wait_init("first");

    load_chk("top word", 32'h3FC, 2'b10, 1'b0, 32'h0);
    step();
    check("top word single pulse", {31'b0, read_valid}, 32'h0);

    op(1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h12345678);
    check("store no read_valid", {31'b0, read_valid}, 32'h0);
    load_chk("word0", 32'h0, 2'b10, 1'b0, 32'h12345678);

    set_req(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
    step();
    check("b2b first rv", {31'b0, read_valid}, 32'h1);
    check("b2b first data", data_out, 32'h12345678);
    set_req(1'b0, 1'b1, 32'h4, 2'b10, 1'b0, 32'h0);
    step();
    idle_inputs();
    check("b2b second rv", {31'b0, read_valid}, 32'h1);
    check("b2b second data", data_out, 32'h0);
    step();
    check("b2b done rv", {31'b0, read_valid}, 32'h0);

    op(1'b1, 1'b0, 32'h5, 2'b00, 1'b0, 32'hFFFFFFAB);
    load_chk("word4 after byte", 32'h4, 2'b10, 1'b0, 32'h0000AB00);
    load_chk("sbyte5", 32'h5, 2'b00, 1'b0, 32'hFFFFFFAB);
    load_chk("ubyte5", 32'h5, 2'b00, 1'b1, 32'h000000AB);
    load_chk("shalf4", 32'h4, 2'b01, 1'b0, 32'hFFFFAB00);
    load_chk("uhalf4", 32'h4, 2'b01, 1'b1, 32'h0000AB00);
    load_chk("word unsigned ignored", 32'h4, 2'b10, 1'b1, 32'h0000AB00);

    fault_chk("half store 0x3", 1'b1, 1'b0, 32'h3, 2'b01, 32'h0000FFFF, 32'h0000AB00);
    fault_chk("word load 0x2", 1'b0, 1'b1, 32'h2, 2'b10, 32'h0, 32'h12345678);
    fault_chk("word store 0x400", 1'b1, 1'b0, 32'h400, 2'b10, 32'hCAFEF00D, 32'h12345678);
    fault_chk("size 11", 1'b1, 1'b0, 32'h0, 2'b11, 32'hFFFFFFFF, 32'h12345678);
    fault_chk("we and re", 1'b1, 1'b1, 32'h0, 2'b10, 32'h11111111, 32'h12345678);

    set_req(1'b0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    step();
    idle_inputs();
    check("reset mid read rv", {31'b0, read_valid}, 32'h0);
    check("reset mid read data", data_out, 32'h0);
    check("reset mid read busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;

    // Stores late in the sweep hit words already zeroed, so a leak would survive.
    n_cyc = 0;
    do begin
      if (n_cyc >= 250) set_req(1'b1, 1'b0, 32'h8, 2'b10, 1'b0, 32'hDEADBEEF);
      else idle_inputs();
      step();
      n_cyc++;
      if (n_cyc > 250) check("busy store no fault", {31'b0, fault}, 32'h0);
    end while (busy && n_cyc < 400);
    idle_inputs();
    check("second init edges", 32'(n_cyc), 32'd256);

    load_chk("word8 after busy store", 32'h8, 2'b10, 1'b0, 32'h0);
    load_chk("word0 cleared by rerun", 32'h0, 2'b10, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
